// File: rtl/serin_pkg.sv
// -----------------------------------------------------------------------------
// serin_pkg
// Shared definitions for the serin_rx serial receiver:
//   - state_t             : receiver FSM state encoding
//   - *_MIN / *_MAX       : legal ranges for DATA_BITS and STOP_BITS
//   - cnt_width()         : width of the bit counter for a given frame shape
// -----------------------------------------------------------------------------
package serin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    // One spare bit above what the longest phase needs, so the counter can
    // never wrap inside the legal parameter range.
    function automatic int cnt_width(input int data_bits, input int stop_bits);
        return $clog2(data_bits + stop_bits) + 1;
    endfunction

endpackage

// File: rtl/serin_rx_if.sv
// -----------------------------------------------------------------------------
// serin_rx_if
// Host-side register/handshake bundle of the serin_rx receiver.
//   rd_ack    : host -> rx, one-clk strobe, rx_data has been read
//   skres     : host -> rx, one-clk strobe, clear latched error flags
//   rx_data   : rx -> host, last completed frame payload
//   rx_done   : rx -> host, one-clk pulse per completed frame
//   rx_valid  : rx -> host, rx_data not yet acknowledged
//   sdi_busy  : rx -> host, frame in progress
//   n_framer  : rx -> host, latched framing error (active-low)
//   n_overrun : rx -> host, latched overrun error (active-low)
// Modports: master = host side, slave = receiver side.
// -----------------------------------------------------------------------------
interface serin_rx_if #(
    parameter int DATA_BITS = 8
);

    logic                 rd_ack;
    logic                 skres;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 rx_valid;
    logic                 sdi_busy;
    logic                 n_framer;
    logic                 n_overrun;

    modport master (
        output rd_ack, skres,
        input  rx_data, rx_done, rx_valid, sdi_busy, n_framer, n_overrun
    );

    modport slave (
        input  rd_ack, skres,
        output rx_data, rx_done, rx_valid, sdi_busy, n_framer, n_overrun
    );

endinterface

// File: rtl/serin_shift.sv
// -----------------------------------------------------------------------------
// serin_shift
// Right-shifting payload register for an LSB-first serial stream: each
// enabled clock moves din into the MSB, so after WIDTH shifts the first
// received bit sits in q[0].
//   clk      : system clock, rising edge
//   reset    : synchronous, active-high, clears q
//   shift_en : shift one bit in this clk
//   din      : serial bit to shift in
//   q        : parallel payload
// -----------------------------------------------------------------------------
module serin_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serin_rx.sv
// -----------------------------------------------------------------------------
// serin_rx
// Asynchronous-serial frame receiver (start bit, DATA_BITS LSB-first, then
// STOP_BITS stop bits). The line is sampled only on bit_tick, which the
// surrounding logic places at bit centres.
//   clk      : system clock, rising edge
//   reset    : synchronous, active-high
//   sdi      : asynchronous serial input, idle high
//   bit_tick : one-clk strobe, the only sampling instant
//   host     : serin_rx_if.slave, host handshake, payload and status flags
// Parameters: DATA_BITS (5..9), STOP_BITS (1..2).
// -----------------------------------------------------------------------------
module serin_rx
    import serin_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sdi,
    input  logic        bit_tick,
    serin_rx_if.slave   host
);

    localparam int CNT_W = cnt_width(DATA_BITS, STOP_BITS);

    logic                 sdi_meta;
    logic                 sdi_sync;
    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 frame_err;
    logic                 frame_err_nxt;
    logic                 shift_en;
    logic                 complete;
    logic                 complete_err;
    logic [DATA_BITS-1:0] payload;

    // Two-flop synchronizer. Reset to 1 so a reset never looks like a start
    // bit on the following tick.
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples the pre-edge value of the others; blocking here would collapse
    // the two stages into one.
    always_ff @(posedge clk) begin
        if (reset) begin
            sdi_meta <= 1'b1;
            sdi_sync <= 1'b1;
        end else begin
            sdi_meta <= sdi;
            sdi_sync <= sdi_meta;
        end
    end

    serin_shift #(.WIDTH(DATA_BITS)) u_shift (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .din      (sdi_sync),
        .q        (payload)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        frame_err_nxt = frame_err;
        shift_en      = 1'b0;
        complete      = 1'b0;
        complete_err  = 1'b0;
        if (bit_tick) begin
            unique case (state)
                IDLE: begin
                    if (!sdi_sync) begin
                        state_nxt     = DATA;
                        cnt_nxt       = '0;
                        frame_err_nxt = 1'b0;
                    end
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (cnt == CNT_W'(DATA_BITS - 1)) begin
                        state_nxt = STOP;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (!sdi_sync) begin
                        frame_err_nxt = 1'b1;
                    end
                    if (cnt == CNT_W'(STOP_BITS - 1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        complete  = 1'b1;
                        // Include the current stop sample, not yet in frame_err.
                        complete_err = frame_err | ~sdi_sync;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Registered host-side outputs. Completion takes precedence over the
    // host strobes so a new error or new data is never lost to a coincident
    // skres or rd_ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            host.rx_data   <= '0;
            host.rx_done   <= 1'b0;
            host.rx_valid  <= 1'b0;
            host.sdi_busy  <= 1'b0;
            host.n_framer  <= 1'b1;
            host.n_overrun <= 1'b1;
        end else begin
            host.rx_done  <= complete;
            host.sdi_busy <= (state_nxt != IDLE);

            if (complete) begin
                host.rx_data <= payload;
            end

            if (complete) begin
                host.rx_valid <= 1'b1;
            end else if (host.rd_ack) begin
                host.rx_valid <= 1'b0;
            end

            if (complete && complete_err) begin
                host.n_framer <= 1'b0;
            end else if (host.skres) begin
                host.n_framer <= 1'b1;
            end

            // Overrun only when unread data is overwritten; an rd_ack in the
            // same clk means the host already took the old word.
            if (complete && host.rx_valid && !host.rd_ack) begin
                host.n_overrun <= 1'b0;
            end else if (host.skres) begin
                host.n_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serin_rx.sv
// -----------------------------------------------------------------------------
// tb_serin_rx
// Directed, table-driven bench for serin_rx. dut1 uses default parameters
// (8 data, 1 stop); dut2 uses 7 data bits and 2 stop bits. Both share the
// serial line; bit_tick is steered to one of them by sel2.
// -----------------------------------------------------------------------------
module tb_serin_rx;

    logic clk = 1'b0;
    logic reset;
    logic sdi;
    logic bit_tick;
    logic rd_ack;
    logic skres;
    logic sel2;
    logic tick1;
    logic tick2;

    int total = 0;
    int bad = 0;
    int done_cnt1 = 0;
    int done_cnt2 = 0;

    always #5 clk = ~clk;

    assign tick1 = bit_tick & ~sel2;
    assign tick2 = bit_tick & sel2;

    serin_rx_if #(.DATA_BITS(8)) if1 ();
    serin_rx_if #(.DATA_BITS(7)) if2 ();

    assign if1.rd_ack = rd_ack & ~sel2;
    assign if1.skres  = skres & ~sel2;
    assign if2.rd_ack = rd_ack & sel2;
    assign if2.skres  = skres & sel2;

    serin_rx #(.DATA_BITS(8), .STOP_BITS(1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .sdi      (sdi),
        .bit_tick (tick1),
        .host     (if1)
    );

    serin_rx #(.DATA_BITS(7), .STOP_BITS(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .sdi      (sdi),
        .bit_tick (tick2),
        .host     (if2)
    );

    always @(negedge clk) begin
        if (if1.rx_done) done_cnt1 <= done_cnt1 + 1;
        if (if2.rx_done) done_cnt2 <= done_cnt2 + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the tick clk,
    // where registered results of that tick are visible.
    task automatic send_bit(input logic b, input logic ack, input logic sk);
        sdi = b;
        repeat (3) @(negedge clk);
        bit_tick = 1'b1;
        rd_ack   = ack;
        skres    = sk;
        @(negedge clk);
        bit_tick = 1'b0;
        rd_ack   = 1'b0;
        skres    = 1'b0;
    endtask

    task automatic send_frame(input logic [8:0] data, input int nbits, input int nstop,
                              input logic stop0, input logic stop1,
                              input logic ack_last, input logic sk_last);
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(data[i], 1'b0, 1'b0);
        for (int s = 0; s < nstop; s++) begin
            if (s == nstop - 1) send_bit((s == 0) ? stop0 : stop1, ack_last, sk_last);
            else                send_bit(stop0, 1'b0, 1'b0);
        end
        sdi = 1'b1;
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    task automatic pulse_skres();
        skres = 1'b1;
        @(negedge clk);
        skres = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ack_first;
        logic       skres_after;
        logic       exp_framer;
        logic       exp_overrun;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int exp_done;

        vecs[0] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; sdi = 1'b1; bit_tick = 1'b0; rd_ack = 1'b0; skres = 1'b0; sel2 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("reset rx_data",   32'(if1.rx_data),   32'h0);
        check("reset rx_done",   32'(if1.rx_done),   32'h0);
        check("reset rx_valid",  32'(if1.rx_valid),  32'h0);
        check("reset sdi_busy",  32'(if1.sdi_busy),  32'h0);
        check("reset n_framer",  32'(if1.n_framer),  32'h1);
        check("reset n_overrun", 32'(if1.n_overrun), 32'h1);
        check("reset dut2 n_framer", 32'(if2.n_framer), 32'h1);

        // Idle ticks with line high do nothing.
        send_bit(1'b1, 1'b0, 1'b0);
        check("idle tick busy", 32'(if1.sdi_busy), 32'h0);

        exp_done = 0;
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].ack_first) pulse_ack();
            send_frame({1'b0, vecs[v].data}, 8, 1, vecs[v].stop, 1'b1, 1'b0, 1'b0);
            exp_done++;
            check($sformatf("vec%0d rx_data", v),   32'(if1.rx_data),   32'(vecs[v].data));
            check($sformatf("vec%0d rx_done", v),   32'(if1.rx_done),   32'h1);
            check($sformatf("vec%0d rx_valid", v),  32'(if1.rx_valid),  32'h1);
            check($sformatf("vec%0d sdi_busy", v),  32'(if1.sdi_busy),  32'h0);
            check($sformatf("vec%0d n_framer", v),  32'(if1.n_framer),  32'(vecs[v].exp_framer));
            check($sformatf("vec%0d n_overrun", v), 32'(if1.n_overrun), 32'(vecs[v].exp_overrun));
            @(negedge clk);
            check($sformatf("vec%0d rx_done low", v), 32'(if1.rx_done), 32'h0);
            check($sformatf("vec%0d done count", v),  32'(done_cnt1),   32'(exp_done));
            if (vecs[v].skres_after) begin
                pulse_skres();
                check($sformatf("vec%0d skres n_framer", v),  32'(if1.n_framer),  32'h1);
                check($sformatf("vec%0d skres n_overrun", v), 32'(if1.n_overrun), 32'h1);
            end
        end

        // Overrun sequence and rd_ack coincident with completion.
        pulse_ack();
        check("ack clears valid", 32'(if1.rx_valid), 32'h0);
        send_frame(9'h011, 8, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ovr first n_overrun", 32'(if1.n_overrun), 32'h1);
        send_frame(9'h022, 8, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ovr rx_data",   32'(if1.rx_data),   32'h22);
        check("ovr n_overrun", 32'(if1.n_overrun), 32'h0);
        pulse_skres();
        check("ovr skres", 32'(if1.n_overrun), 32'h1);
        send_frame(9'h033, 8, 1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("ack@done n_overrun", 32'(if1.n_overrun), 32'h1);
        check("ack@done rx_valid",  32'(if1.rx_valid),  32'h1);
        check("ack@done rx_data",   32'(if1.rx_data),   32'h33);
        pulse_ack();
        check("ack after done", 32'(if1.rx_valid), 32'h0);

        // skres coincident with a framing error: the error wins.
        send_frame(9'h055, 8, 1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("skres vs err n_framer", 32'(if1.n_framer), 32'h0);
        pulse_skres();
        check("skres after err", 32'(if1.n_framer), 32'h1);

        // Reset mid-frame (after 4th data bit of 0xFF), coincident with a tick.
        exp_done = done_cnt1;
        send_bit(1'b0, 1'b0, 1'b0);
        check("start busy", 32'(if1.sdi_busy), 32'h1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
        reset = 1'b1; bit_tick = 1'b1; rd_ack = 1'b1; skres = 1'b1;
        @(negedge clk);
        reset = 1'b0; bit_tick = 1'b0; rd_ack = 1'b0; skres = 1'b0;
        check("midrst busy",    32'(if1.sdi_busy),  32'h0);
        check("midrst rx_data", 32'(if1.rx_data),   32'h0);
        check("midrst rx_done", 32'(if1.rx_done),   32'h0);
        check("midrst valid",   32'(if1.rx_valid),  32'h0);
        check("midrst framer",  32'(if1.n_framer),  32'h1);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("midrst no done", 32'(done_cnt1), 32'(exp_done));
        check("midrst rx_data after", 32'(if1.rx_data), 32'h0);

        // One-clk low glitch between ticks while idle.
        sdi = 1'b0;
        @(negedge clk);
        sdi = 1'b1;
        send_bit(1'b1, 1'b0, 1'b0);
        check("glitch busy", 32'(if1.sdi_busy), 32'h0);

        // Synchronizer latency: a low only one clk old must not be seen yet.
        sdi = 1'b0;
        @(negedge clk);
        bit_tick = 1'b1;
        @(negedge clk);
        bit_tick = 1'b0;
        sdi = 1'b1;
        check("sync latency busy", 32'(if1.sdi_busy), 32'h0);
        repeat (4) @(negedge clk);
        check("glitch no done", 32'(done_cnt1), 32'(exp_done));

        // dut2: 7 data bits, 2 stop bits.
        sel2 = 1'b1;
        send_frame(9'h045, 7, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        check("d2 rx_data",  32'(if2.rx_data),  32'h45);
        check("d2 rx_done",  32'(if2.rx_done),  32'h1);
        check("d2 n_framer", 32'(if2.n_framer), 32'h0);
        @(negedge clk);
        check("d2 done count", 32'(done_cnt2), 32'h1);
        pulse_skres();
        pulse_ack();
        send_frame(9'h02B, 7, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        check("d2 ok rx_data",   32'(if2.rx_data),   32'h2B);
        check("d2 ok n_framer",  32'(if2.n_framer),  32'h1);
        check("d2 ok n_overrun", 32'(if2.n_overrun), 32'h1);
        check("d2 dut1 untouched", 32'(done_cnt1), 32'(exp_done));
        sel2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serin_rx.md
SERIN_RX -- requirements
Module: serin_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (legal 5..9).
REQ-002 SHALL have parameter STOP_BITS, default 1, number of stop bits checked (legal 1 or 2).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sdi  input  1  asynchronous serial line; idle high, LSB first.
REQ-006 SHALL have port bit_tick  input  1  one-clk strobe at bit-centre rate; only sampling instant.
REQ-007 SHALL have port rd_ack  input  1  one-clk strobe; host has read rx_data.
REQ-008 SHALL have port skres  input  1  one-clk strobe; clears latched error flags.
REQ-009 SHALL have port rx_data  output  DATA_BITS  last completed frame payload.
REQ-010 SHALL have port rx_done  output  1  one-clk pulse per completed frame (IRQ source).
REQ-011 SHALL have port rx_valid  output  1  rx_data unread.
REQ-012 SHALL have port sdi_busy  output  1  high while a frame is in progress.
REQ-013 SHALL have port n_framer  output  1  latched framing error, active-low.
REQ-014 SHALL have port n_overrun  output  1  latched overrun error, active-low.

Function
REQ-015 SHALL pass sdi through a 2-flop synchronizer; all sampling uses the synchronized value (2-clk latency).
REQ-016 SHALL implement states IDLE, DATA, STOP; state changes only on a clk where bit_tick=1.
REQ-017 IDLE: synced sdi=0 at bit_tick -> DATA, bit counter=0, sdi_busy=1 from next clk; sdi=1 stays IDLE.
REQ-018 DATA: each bit_tick shifts synced sdi into payload LSB-first; after DATA_BITS ticks -> STOP.
REQ-019 STOP: samples STOP_BITS ticks; any sample=0 marks frame framing-errored; after last stop tick -> IDLE.
REQ-020 On last stop tick SHALL, next clk: load rx_data, rx_done=1 for one clk, rx_valid=1, sdi_busy=0.
REQ-021 Framing-errored frame SHALL still load rx_data and pulse rx_done, and SHALL clear n_framer to 0.
REQ-022 Completion while rx_valid=1 and no rd_ack that clk SHALL clear n_overrun to 0 and overwrite rx_data.
REQ-023 rd_ack SHALL clear rx_valid next clk; rd_ack coincident with completion -> rx_valid stays 1, no overrun.
REQ-024 skres SHALL set n_framer and n_overrun to 1 next clk; skres coincident with new error -> error (0) wins.
REQ-025 bit_tick while sdi_busy=0 and sdi=1 SHALL have no effect; sdi toggling between ticks SHALL be ignored.
REQ-026 bit counter SHALL be $clog2(DATA_BITS+STOP_BITS)+1 bits wide, saturating never reached; no wrap in legal range.

Reset
REQ-027 reset=1 SHALL, at next clk edge, force state IDLE, synchronizer flops=1, counter=0.
REQ-028 Reset values SHALL be: rx_data=0, rx_done=0, rx_valid=0, sdi_busy=0, n_framer=1, n_overrun=1.
REQ-029 reset mid-frame SHALL abort the frame with no rx_done and no error flag change beyond REQ-028.
REQ-030 reset SHALL take priority over bit_tick, rd_ack and skres in the same clk.

Structure
REQ-031 State encodings and DATA_BITS/STOP_BITS legal-range constants SHALL live in shared package serin_pkg.
REQ-032 Payload shift register SHALL be sub-module serin_shift (parameter WIDTH; ports clk, reset, shift_en, din, q).
REQ-033 All outputs SHALL be registered; no combinational path from sdi or bit_tick to any output.

Verification
REQ-034 Default params, frame 0x5A with 1 stop bit -> one rx_done, rx_data=0x5A, rx_valid=1, n_framer=1.
REQ-035 Frame 0x3C with stop bit=0 -> rx_data=0x3C, rx_done pulses, n_framer=0; then skres -> n_framer=1.
REQ-036 Two frames 0x11, 0x22, no rd_ack -> rx_data=0x22, n_overrun=0; rd_ack on 2nd completion clk -> n_overrun=1.
REQ-037 reset asserted after 4th data bit of 0xFF -> sdi_busy=0 next clk, no rx_done, rx_data=0.
REQ-038 DATA_BITS=7, STOP_BITS=2, frame 0x45, second stop=0 -> rx_data=0x45, n_framer=0.
REQ-039 Glitch sdi low for 1 clk between ticks while IDLE -> state stays IDLE, sdi_busy=0.
